// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment codes are active-low, ordered g,f,e,d,c,b,a (bit 6 down to bit 0).
package seg_display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to active-low gfedcba decoder; zero latency.
// No flow control: output follows input within the same cycle.
module hex_to_7seg
    import seg_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_hex];

endmodule

// File: rtl/seg_alarm_driver.sv
// Drives a 4-digit common-anode display (frame-snapshotted scan), status LEDs and a blink-gated buzzer.
// Inputs are registered once; display updates on refresh ticks; no backpressure, outputs are free-running.
module seg_alarm_driver
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int TONE_DIV    = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hexa3,
    input  logic [3:0] hexa2,
    input  logic [3:0] hexa1,
    input  logic [3:0] hexa0,
    input  logic       luz_normal,
    input  logic       luz_alerta,
    input  logic       alarma_alerta,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       led_normal,
    output logic       led_alerta,
    output logic       buzzer
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);
    localparam logic [1:0]    IDX_LAST   = 2'(NUM_DIGITS - 1);

    logic [NUM_DIGITS-1:0][3:0] r_hex;
    logic [NUM_DIGITS-1:0][3:0] r_snap;
    logic                       r_normal;
    logic                       r_alert;
    logic                       r_alarm;

    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [TW-1:0] r_tone_cnt;
    logic          r_buzzer;

    logic       w_tick;
    logic [1:0] w_idx_nxt;
    logic [3:0] w_sel_digit;
    logic [6:0] w_seg;
    logic       w_gate;

    assign w_tick    = (r_ref_cnt == REF_LAST);
    assign w_idx_nxt = r_idx + 2'd1;
    // On the frame-start tick the snapshot is loading this same edge, so decode straight from hex_r.
    assign w_sel_digit = (r_idx == IDX_LAST) ? r_hex[w_idx_nxt] : r_snap[w_idx_nxt];
    assign w_gate      = r_alarm & r_blink_on;

    hex_to_7seg u_dec (
        .i_hex (w_sel_digit),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hex    <= '0;
            r_normal <= 1'b0;
            r_alert  <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_hex    <= {hexa3, hexa2, hexa1, hexa0};
            r_normal <= luz_normal;
            r_alert  <= luz_alerta;
            r_alarm  <= alarma_alerta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= IDX_LAST;
            r_snap    <= '0;
            r_an      <= AN_OFF;
            r_seg     <= SEG_OFF;
        end else if (w_tick) begin
            r_ref_cnt <= '0;
            r_idx     <= w_idx_nxt;
            if (r_idx == IDX_LAST) begin
                r_snap <= r_hex;
            end
            r_an  <= ~(4'b0001 << w_idx_nxt);
            r_seg <= w_seg;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (!r_alert) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tone_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else if (!w_gate) begin
            r_tone_cnt <= '0;
            r_buzzer   <= 1'b0;
        end else if (r_tone_cnt == TONE_LAST) begin
            r_tone_cnt <= '0;
            r_buzzer   <= ~r_buzzer;
        end else begin
            r_tone_cnt <= r_tone_cnt + 1'b1;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign led_normal = r_normal & ~r_alert;
    assign led_alerta = r_alert & r_blink_on;
    assign buzzer     = r_buzzer;

endmodule

// File: tb/tb_seg_alarm_driver.sv
// Directed bench for seg_alarm_driver with small dividers: scan, snapshot, blink, buzzer, reset, decode.
module tb_seg_alarm_driver;

    localparam int RD = 4;
    localparam int BD = 8;
    localparam int TD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hexa3, hexa2, hexa1, hexa0;
    logic       luz_normal, luz_alerta, alarma_alerta;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, led_normal, led_alerta, buzzer;

    int total = 0;
    int bad   = 0;

    seg_alarm_driver #(
        .REFRESH_DIV (RD),
        .BLINK_DIV   (BD),
        .TONE_DIV    (TD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hexa3         (hexa3),
        .hexa2         (hexa2),
        .hexa1         (hexa1),
        .hexa0         (hexa0),
        .luz_normal    (luz_normal),
        .luz_alerta    (luz_alerta),
        .alarma_alerta (alarma_alerta),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .led_normal    (led_normal),
        .led_alerta    (led_alerta),
        .buzzer        (buzzer)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] hexa;
        logic [3:0]  an_exp;
        logic [6:0]  seg_exp;
    } scan_vec_t;

    typedef struct {
        logic [3:0] hex;
        logic [6:0] seg_exp;
    } dec_vec_t;

    scan_vec_t scan_tab [8];
    dec_vec_t  dec_tab  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hex(input logic [15:0] h);
        {hexa3, hexa2, hexa1, hexa0} = h;
    endtask

    task automatic chk_blank(input string name);
        chk({name, "_an"},  32'(an),  32'h0000000F);
        chk({name, "_seg"}, 32'(seg), 32'h0000007F);
    endtask

    // Alert phase model: 8 clocks on / 8 off; buzzer high on phase clocks 2,3,6,7.
    task automatic chk_alert(input string name, input int j);
        logic exp_led;
        logic exp_buz;
        int   p;
        exp_led = ((j / BD) % 2) == 0;
        p       = j % BD;
        exp_buz = exp_led && ((p % (2 * TD)) >= TD);
        chk({name, "_led_alerta"}, 32'(led_alerta), 32'(exp_led));
        chk({name, "_buzzer"},     32'(buzzer),     32'(exp_buz));
        chk({name, "_led_normal"}, 32'(led_normal), 32'h0);
    endtask

    initial begin
        scan_tab[0] = '{16'h8497, 4'b1110, 7'b1111000};
        scan_tab[1] = '{16'h1234, 4'b1101, 7'b0010000};
        scan_tab[2] = '{16'h1234, 4'b1011, 7'b0011001};
        scan_tab[3] = '{16'h1234, 4'b0111, 7'b0000000};
        scan_tab[4] = '{16'h1234, 4'b1110, 7'b0011001};
        scan_tab[5] = '{16'h1234, 4'b1101, 7'b0110000};
        scan_tab[6] = '{16'h1234, 4'b1011, 7'b0100100};
        scan_tab[7] = '{16'h1234, 4'b0111, 7'b1111001};

        dec_tab[0]  = '{4'h0, 7'b1000000};
        dec_tab[1]  = '{4'h1, 7'b1111001};
        dec_tab[2]  = '{4'h2, 7'b0100100};
        dec_tab[3]  = '{4'h3, 7'b0110000};
        dec_tab[4]  = '{4'h4, 7'b0011001};
        dec_tab[5]  = '{4'h5, 7'b0010010};
        dec_tab[6]  = '{4'h6, 7'b0000010};
        dec_tab[7]  = '{4'h7, 7'b1111000};
        dec_tab[8]  = '{4'h8, 7'b0000000};
        dec_tab[9]  = '{4'h9, 7'b0010000};
        dec_tab[10] = '{4'hA, 7'b0001000};
        dec_tab[11] = '{4'hB, 7'b0000011};
        dec_tab[12] = '{4'hC, 7'b1000110};
        dec_tab[13] = '{4'hD, 7'b0100001};
        dec_tab[14] = '{4'hE, 7'b0000110};
        dec_tab[15] = '{4'hF, 7'b0001110};

        reset         = 1'b1;
        luz_normal    = 1'b0;
        luz_alerta    = 1'b0;
        alarma_alerta = 1'b0;
        set_hex(16'h8497);
        repeat (2) step();
        chk_blank("reset");
        chk("reset_dp",         32'(dp),         32'h1);
        chk("reset_buzzer",     32'(buzzer),     32'h0);
        chk("reset_led_normal", 32'(led_normal), 32'h0);
        chk("reset_led_alerta", 32'(led_alerta), 32'h0);

        // Scan start-up and frame-consistent snapshot.
        reset = 1'b0;
        for (int c = 1; c < RD; c++) begin
            step();
            chk_blank("startup");
        end
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < RD; c++) begin
                step();
                chk("scan_an",  32'(an),  32'(scan_tab[s].an_exp));
                chk("scan_seg", 32'(seg), 32'(scan_tab[s].seg_exp));
                if (c == 0) set_hex(scan_tab[s].hexa);
            end
        end
        chk("scan_dp", 32'(dp), 32'h1);

        // Normal flag alone, then alert with priority over normal.
        luz_normal = 1'b1;
        step();
        chk("normal_led_normal", 32'(led_normal), 32'h1);
        chk("normal_led_alerta", 32'(led_alerta), 32'h0);
        chk("normal_buzzer",     32'(buzzer),     32'h0);
        luz_alerta    = 1'b1;
        alarma_alerta = 1'b1;
        for (int j = 0; j < 28; j++) begin
            step();
            chk_alert("alert1", j);
        end

        // Drop during an off phase, re-raise 5 clocks later: must restart in the on phase.
        luz_alerta    = 1'b0;
        alarma_alerta = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("gap_led_alerta", 32'(led_alerta), 32'h0);
            chk("gap_led_normal", 32'(led_normal), 32'h1);
            chk("gap_buzzer",     32'(buzzer),     32'h0);
        end
        luz_alerta    = 1'b1;
        alarma_alerta = 1'b1;
        for (int j = 0; j < 19; j++) begin
            step();
            chk_alert("alert2", j);
        end

        // Asynchronous reset mid-frame with buzzer high.
        chk("pre_reset_buzzer", 32'(buzzer), 32'h1);
        reset = 1'b1;
        #1;
        chk_blank("async_reset");
        chk("async_reset_buzzer",     32'(buzzer),     32'h0);
        chk("async_reset_led_alerta", 32'(led_alerta), 32'h0);
        chk("async_reset_led_normal", 32'(led_normal), 32'h0);
        luz_normal    = 1'b0;
        luz_alerta    = 1'b0;
        alarma_alerta = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 1; c < RD; c++) begin
            step();
            chk_blank("restart");
        end
        step();
        chk("restart_an",  32'(an),  32'h0000000E);
        chk("restart_seg", 32'(seg), 32'b0011001);

        // Decode sweep on the rightmost digit, one value per frame.
        for (int v = 0; v < 16; v++) begin
            hexa0 = dec_tab[v].hex;
            repeat (4 * RD) step();
            chk("sweep_an",  32'(an),  32'h0000000E);
            chk("sweep_seg", 32'(seg), 32'(dec_tab[v].seg_exp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
